// File: rtl/warp_scheduler_if.sv
// FIFO-pair and kernel-lane signals between warp_scheduler (master) and its
// environment (slave: Xillybus FIFOs plus the kernel array).
interface warp_scheduler_if #(
  parameter int LANES = 32
);
  logic                  recv_rden;
  logic                  recv_empty;
  logic [31:0]           recv_data;
  logic                  recv_valid;
  logic                  send_wren;
  logic [31:0]           send_data;
  logic                  send_full;
  logic [LANES*16-1:0]   lane_in_data;
  logic [LANES-1:0]      lane_in_valid;
  logic [LANES*16-1:0]   lane_out_data;
  logic [LANES-1:0]      lane_out_valid;

  modport master (
    output recv_rden, send_wren, send_data, lane_in_data, lane_in_valid,
    input  recv_empty, recv_data, recv_valid, send_full, lane_out_data, lane_out_valid
  );

  modport slave (
    input  recv_rden, send_wren, send_data, lane_in_data, lane_in_valid,
    output recv_empty, recv_data, recv_valid, send_full, lane_out_data, lane_out_valid
  );
endinterface

// File: rtl/warp_scheduler.sv
// Batches a 512-element job through LANES kernel instances: load packed words,
// fire all lanes, collect each result once, repack and drain, repeat per batch.
module warp_scheduler #(
  parameter int ELEMS   = 512,
  parameter int LANES   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             bus_clk,
  input  logic             rst_n,
  input  logic             quiesce,
  input  logic             host_open,
  warp_scheduler_if.master bus,
  output logic [4:0]       state,
  output logic             job_done,
  output logic             err
);
  localparam int WORDS   = LANES / 2;
  localparam int BATCHES = ELEMS / LANES;
  localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int SW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW      = $clog2(WORDS) + 1;
  localparam int TW      = $clog2(TIMEOUT) + 1;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_LOAD  = 5'b00010,
    S_ISSUE = 5'b00100,
    S_WAIT  = 5'b01000,
    S_DRAIN = 5'b10000
  } state_t;

  state_t                  st_q, st_d;
  logic [BW-1:0]           batch_q;
  logic [CW-1:0]           rd_cnt_q, wr_cnt_q, snd_cnt_q;
  logic [TW-1:0]           wait_cnt_q;
  logic [WORDS-1:0][31:0]  lane_w;
  logic [LANES-1:0][15:0]  res;
  logic [WORDS-1:0][31:0]  res_w;
  logic [LANES-1:0]        sticky;
  logic abort, rd_stb, wr_stb, load_done, last_word, last_batch;
  logic all_done, t_out, sticky_clr, cap_en;

  assign abort      = quiesce || !host_open;
  assign rd_stb     = (st_q == S_LOAD) && !bus.recv_empty && (rd_cnt_q < CW'(WORDS));
  assign wr_stb     = (st_q == S_DRAIN) && !bus.send_full;
  // Leave LOAD on the same edge that stores the last word.
  assign load_done  = (wr_cnt_q == CW'(WORDS)) ||
                      (bus.recv_valid && (wr_cnt_q == CW'(WORDS - 1)));
  assign last_word  = snd_cnt_q == CW'(WORDS - 1);
  assign last_batch = batch_q == BW'(BATCHES - 1);
  assign all_done   = &(sticky | bus.lane_out_valid);
  assign t_out      = wait_cnt_q == TW'(TIMEOUT - 1);
  assign sticky_clr = (st_q == S_IDLE) || (st_q == S_ISSUE);
  assign cap_en     = st_q == S_WAIT;

  assign state             = st_q;
  assign bus.recv_rden     = rd_stb;
  assign bus.send_wren     = wr_stb;
  assign bus.lane_in_valid = {LANES{st_q == S_ISSUE}};
  assign bus.lane_in_data  = lane_w;
  assign res_w             = res;
  assign bus.send_data     = (st_q == S_DRAIN) ? res_w[snd_cnt_q[SW-1:0]] : '0;

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  st_d = S_LOAD;
      S_LOAD:  if (load_done) st_d = S_ISSUE;
      S_ISSUE: st_d = S_WAIT;
      S_WAIT:  if (all_done) st_d = S_DRAIN;
               else if (t_out) st_d = S_IDLE;
      S_DRAIN: if (wr_stb && last_word) st_d = last_batch ? S_IDLE : S_LOAD;
      default: st_d = S_IDLE;
    endcase
    if (abort) st_d = S_IDLE;
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      batch_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      snd_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lane_w     <= '0;
      job_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      st_q     <= st_d;
      job_done <= wr_stb && last_word && last_batch && !abort;
      if (st_q == S_IDLE && st_d == S_LOAD) err <= 1'b0;
      else if (st_q == S_WAIT && t_out && !all_done && !abort) err <= 1'b1;

      wait_cnt_q <= '0;
      if (st_q == S_WAIT && wait_cnt_q != TW'(TIMEOUT)) wait_cnt_q <= wait_cnt_q + TW'(1);

      if (st_q == S_IDLE || st_d == S_IDLE) begin
        batch_q   <= '0;
        rd_cnt_q  <= '0;
        wr_cnt_q  <= '0;
        snd_cnt_q <= '0;
      end else if (st_q == S_DRAIN && st_d == S_LOAD) begin
        batch_q   <= batch_q + BW'(1);
        rd_cnt_q  <= '0;
        wr_cnt_q  <= '0;
        snd_cnt_q <= '0;
      end else begin
        if (rd_stb) rd_cnt_q <= rd_cnt_q + CW'(1);
        if (st_q == S_LOAD && bus.recv_valid && wr_cnt_q != CW'(WORDS)) begin
          lane_w[wr_cnt_q[SW-1:0]] <= bus.recv_data;
          wr_cnt_q <= wr_cnt_q + CW'(1);
        end
        if (wr_stb && snd_cnt_q != CW'(WORDS)) snd_cnt_q <= snd_cnt_q + CW'(1);
      end
    end
  end

  // Per-lane capture: first valid after ISSUE wins, held levels are ignored.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    always_ff @(posedge bus_clk or negedge rst_n) begin
      if (!rst_n) begin
        sticky[k] <= 1'b0;
        res[k]    <= '0;
      end else if (sticky_clr) begin
        sticky[k] <= 1'b0;
      end else if (cap_en && bus.lane_out_valid[k] && !sticky[k]) begin
        sticky[k] <= 1'b1;
        res[k]    <= bus.lane_out_data[16*k +: 16];
      end
    end
  end
endmodule
